// File: rtl/div_pkg.sv
// Shared constants for the divider result path: state encoding, BCD digit
// width, display blank code and default operand sizes.
package div_pkg;

    localparam int DIV_WIDTH   = 8;
    localparam int DIV_DIGITS  = 3;
    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } div_bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import div_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/div_result_bcd.sv
// Captures the divider result and converts quotient/remainder to packed BCD
// by double dabble. Define DIV_BCD_BLANK_EN to blank leading zero digits.
module div_result_bcd
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int DIGITS = DIV_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          capture,
    input  logic [WIDTH-1:0]              quotient,
    input  logic [WIDTH-1:0]              remainder,
    input  logic                          not_valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] q_bcd,
    output logic [BCD_DIGIT_W*DIGITS-1:0] r_bcd,
    output logic                          err,
    output logic                          busy,
    output logic                          done
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    div_bcd_state_t state_reg, state_next;

    logic [WIDTH-1:0] lat_q_reg, lat_r_reg;
    logic [WIDTH-1:0] q_bin_reg, r_bin_reg;
    logic [BW-1:0]    q_scr_reg, r_scr_reg;
    logic [CW-1:0]    cnt_reg;
    logic [BW-1:0]    q_bcd_reg, r_bcd_reg;
    logic             err_reg, done_reg;

    logic [BW-1:0]    q_adj, r_adj;
    logic [BW-1:0]    q_scr_next, r_scr_next;
    logic [BW-1:0]    q_fin, r_fin, err_fin;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_q_add3 (
                .din  (q_scr_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dout (q_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
            bcd_add3 u_r_add3 (
                .din  (r_scr_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dout (r_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // BCD half of the {bcd, bin} left shift after the add-3 correction
    assign q_scr_next = {q_adj[BW-2:0], q_bin_reg[WIDTH-1]};
    assign r_scr_next = {r_adj[BW-2:0], r_bin_reg[WIDTH-1]};

`ifdef DIV_BCD_BLANK_EN
    function automatic logic [BW-1:0] blank_lead(input logic [BW-1:0] v);
        logic lead;
        lead       = 1'b1;
        blank_lead = v;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && v[d*BCD_DIGIT_W +: BCD_DIGIT_W] == '0)
                blank_lead[d*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
            else
                lead = 1'b0;
        end
    endfunction

    assign q_fin   = blank_lead(q_scr_next);
    assign r_fin   = blank_lead(r_scr_next);
    assign err_fin = blank_lead('0);
`else
    assign q_fin   = q_scr_next;
    assign r_fin   = r_scr_next;
    assign err_fin = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (capture) state_next = not_valid ? DONE : LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (cnt_reg == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result registers are written on the edge entering DONE, so they are
    // visible for the whole cycle in which done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_q_reg <= '0;
            lat_r_reg <= '0;
            q_bin_reg <= '0;
            r_bin_reg <= '0;
            q_scr_reg <= '0;
            r_scr_reg <= '0;
            cnt_reg   <= '0;
            q_bcd_reg <= '0;
            r_bcd_reg <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (capture) begin
                        lat_q_reg <= quotient;
                        lat_r_reg <= remainder;
                        if (not_valid) begin
                            q_bcd_reg <= err_fin;
                            r_bcd_reg <= err_fin;
                            err_reg   <= 1'b1;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    q_scr_reg <= '0;
                    r_scr_reg <= '0;
                    q_bin_reg <= lat_q_reg;
                    r_bin_reg <= lat_r_reg;
                    cnt_reg   <= CNT_INIT;
                end
                SHIFT: begin
                    q_scr_reg <= q_scr_next;
                    r_scr_reg <= r_scr_next;
                    q_bin_reg <= {q_bin_reg[WIDTH-2:0], 1'b0};
                    r_bin_reg <= {r_bin_reg[WIDTH-2:0], 1'b0};
                    cnt_reg   <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        q_bcd_reg <= q_fin;
                        r_bcd_reg <= r_fin;
                        err_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_bcd = q_bcd_reg;
    assign r_bcd = r_bcd_reg;
    assign err   = err_reg;
    assign done  = done_reg;
    assign busy  = (state_reg != IDLE);

endmodule
